reg_sel_decoder: RTL and testbench

REG_SEL_DECODER -- requirements
Module: reg_sel_decoder

---
 rtl/reg_sel_decoder_pkg.sv | 22 ++
 rtl/reg_sel_decoder_if.sv | 33 +++
 rtl/reg_sel_decoder_onehot.sv | 15 +
 rtl/reg_sel_decoder.sv | 135 +++++++++++++
 tb/tb_reg_sel_decoder.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_sel_decoder_pkg.sv
// Shared definitions for the register-select decoder: the decode mode encodings,
// the reserved-mode rule and the sweep FSM states.
package reg_sel_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_INV    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // The reserved encoding behaves exactly like plain one-hot.
    function automatic mode_e effective_mode(input logic [1:0] raw_mode);
        return (raw_mode == MODE_RSVD) ? MODE_ONEHOT : mode_e'(raw_mode);
    endfunction

endpackage

// File: rtl/reg_sel_decoder_if.sv
// Request/response bus of the register-select decoder: a valid/ready request
// carrying the select index and mode, and the registered decoded lines.
interface reg_sel_decoder_if #(
    parameter int ADDR_W = 5
);
    localparam int OUT_W = 2 ** ADDR_W;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in;
    logic [1:0]        mode;
    logic [OUT_W-1:0]  out;
    logic              out_valid;

    modport master (
        output in_valid,
        output in,
        output mode,
        input  in_ready,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in,
        input  mode,
        output in_ready,
        output out,
        output out_valid
    );

endinterface

// File: rtl/reg_sel_decoder_onehot.sv
// Purely combinational index-to-one-hot core shared by request decodes and
// sweep steps.
module onehot_decode_core #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]      idx,
    output logic [2**ADDR_W-1:0]   lines
);

    always_comb begin
        lines      = '0;
        lines[idx] = 1'b1;
    end

endmodule

// File: rtl/reg_sel_decoder.sv
// Registered register-select decoder: one-cycle decode of accepted requests
// (one-hot / thermometer / inverted) plus a self-timed one-hot clear sweep.
module reg_sel_decoder
    import reg_sel_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter bit ZERO_MASK = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    reg_sel_decoder_if.slave bus,
    input  logic             sweep_start,
    output logic             busy,
    output logic             sweep_done
);

    localparam int OUT_W = 2 ** ADDR_W;

    localparam logic [OUT_W-1:0]  LSB_ONE     = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]  LINE_MASK   = {{(OUT_W-1){1'b1}}, ~ZERO_MASK};
    localparam logic [ADDR_W-1:0] SWEEP_FIRST = ADDR_W'(ZERO_MASK);
    localparam logic [ADDR_W-1:0] SWEEP_LAST  = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              sweep_done_q, sweep_done_d;

    logic              accept;
    logic              sweep_load;
    logic [ADDR_W-1:0] step_idx;
    logic [ADDR_W-1:0] core_idx;
    logic [OUT_W-1:0]  raw_lines;
    logic [OUT_W-1:0]  therm_lines;
    logic [OUT_W-1:0]  dec_lines;

    // busy_q is low exactly when idle with no deferred sweep, so it doubles as the
    // "not ready" term; a sweep_start that collides with a request is deferred.
    assign accept     = bus.in_valid && !busy_q;
    assign sweep_load = pending_q || (!busy_q && sweep_start && !bus.in_valid);
    assign step_idx   = sweep_load ? SWEEP_FIRST : cnt_q + ADDR_W'(1);
    assign core_idx   = (sweep_load || state_q == ST_SWEEP) ? step_idx : bus.in;

    onehot_decode_core #(
        .ADDR_W (ADDR_W)
    ) u_core (
        .idx   (core_idx),
        .lines (raw_lines)
    );

    // Shifting the one-hot up and subtracting one fills every line at or below idx.
    assign therm_lines = {raw_lines[OUT_W-2:0], 1'b0} - LSB_ONE;

    always_comb begin
        unique case (effective_mode(bus.mode))
            MODE_THERM: dec_lines = therm_lines;
            MODE_INV:   dec_lines = ~raw_lines;
            default:    dec_lines = raw_lines;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = 1'b0;
        out_d        = '0;
        out_valid_d  = 1'b0;
        busy_d       = 1'b0;
        sweep_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sweep_load) begin
                    state_d      = ST_SWEEP;
                    cnt_d        = SWEEP_FIRST;
                    out_d        = raw_lines;
                    out_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                    sweep_done_d = (SWEEP_FIRST == SWEEP_LAST);
                end else if (accept) begin
                    out_d       = dec_lines;
                    out_valid_d = 1'b1;
                    pending_d   = sweep_start;
                    busy_d      = sweep_start;
                end
            end
            ST_SWEEP: begin
                // The counter parks on the last line instead of wrapping.
                if (cnt_q != SWEEP_LAST) begin
                    cnt_d        = step_idx;
                    out_d        = raw_lines;
                    out_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                    sweep_done_d = (step_idx == SWEEP_LAST);
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        out_d = out_d & LINE_MASK;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = !busy_q;
    assign busy          = busy_q;
    assign sweep_done    = sweep_done_q;

endmodule

// File: tb/tb_reg_sel_decoder.sv
// Bench for reg_sel_decoder: three instances (5/mask, 5/no-mask, 3/no-mask)
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_reg_sel_decoder;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        iv    [3];
    logic [4:0]  in_s  [3];
    logic [1:0]  md    [3];
    logic        ss    [3];
    logic [31:0] out_s [3];
    logic        ov    [3];
    logic        rdy   [3];
    logic        bsy   [3];
    logic        dn    [3];

    reg_sel_decoder_if #(.ADDR_W(5)) bus0 ();
    reg_sel_decoder_if #(.ADDR_W(5)) bus1 ();
    reg_sel_decoder_if #(.ADDR_W(3)) bus2 ();

    assign bus0.in_valid = iv[0];
    assign bus0.in       = in_s[0];
    assign bus0.mode     = md[0];
    assign out_s[0]      = bus0.out;
    assign ov[0]         = bus0.out_valid;
    assign rdy[0]        = bus0.in_ready;

    assign bus1.in_valid = iv[1];
    assign bus1.in       = in_s[1];
    assign bus1.mode     = md[1];
    assign out_s[1]      = bus1.out;
    assign ov[1]         = bus1.out_valid;
    assign rdy[1]        = bus1.in_ready;

    assign bus2.in_valid = iv[2];
    assign bus2.in       = in_s[2][2:0];
    assign bus2.mode     = md[2];
    assign out_s[2]      = {24'b0, bus2.out};
    assign ov[2]         = bus2.out_valid;
    assign rdy[2]        = bus2.in_ready;

    reg_sel_decoder #(.ADDR_W(5), .ZERO_MASK(1'b1)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0),
        .sweep_start(ss[0]), .busy(bsy[0]), .sweep_done(dn[0])
    );
    reg_sel_decoder #(.ADDR_W(5), .ZERO_MASK(1'b0)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1),
        .sweep_start(ss[1]), .busy(bsy[1]), .sweep_done(dn[1])
    );
    reg_sel_decoder #(.ADDR_W(3), .ZERO_MASK(1'b0)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2),
        .sweep_start(ss[2]), .busy(bsy[2]), .sweep_done(dn[2])
    );

    // ---------------- reference model ----------------
    int          sq     [3][$];   // sweep lines still to be emitted
    bit          defer  [3];      // sweep queued behind a same-cycle request
    logic [31:0] e_out  [3];
    bit          e_valid[3];
    bit          e_busy [3];
    bit          e_done [3];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int aw_of(input int i);
        return (i == 2) ? 3 : 5;
    endfunction

    function automatic bit zm_of(input int i);
        return (i == 0);
    endfunction

    function automatic logic [31:0] ref_decode(input int i, input logic [4:0] idx, input logic [1:0] m);
        logic [31:0] r;
        int n, sel;
        r   = '0;
        n   = 1 << aw_of(i);
        sel = int'(idx) % n;
        for (int k = 0; k < n; k++) begin
            case (m)
                2'b01:   r[k] = (k <= sel);
                2'b10:   r[k] = (k != sel);
                default: r[k] = (k == sel);
            endcase
        end
        if (zm_of(i)) r[0] = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            sq[i].delete();
            defer[i]   = 1'b0;
            e_out[i]   = '0;
            e_valid[i] = 1'b0;
            e_busy[i]  = 1'b0;
            e_done[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit ready, acc;
                int line;
                ready = !e_busy[i];
                acc   = ready && iv[i];
                if (defer[i] || (ready && ss[i] && !acc)) begin
                    defer[i] = 1'b0;
                    for (int k = int'(zm_of(i)); k < (1 << aw_of(i)); k++) sq[i].push_back(k);
                end
                if (sq[i].size() > 0) begin
                    line       = sq[i].pop_front();
                    e_out[i]   = 32'(1) << line;
                    e_valid[i] = 1'b1;
                    e_busy[i]  = 1'b1;
                    e_done[i]  = (sq[i].size() == 0);
                end else if (acc) begin
                    e_out[i]   = ref_decode(i, in_s[i], md[i]);
                    e_valid[i] = 1'b1;
                    e_busy[i]  = ss[i];
                    e_done[i]  = 1'b0;
                    defer[i]   = ss[i];
                end else begin
                    e_out[i]   = '0;
                    e_valid[i] = 1'b0;
                    e_busy[i]  = 1'b0;
                    e_done[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d.out", i),        out_s[i], e_out[i]);
            check($sformatf("i%0d.out_valid", i),  ov[i],    e_valid[i]);
            check($sformatf("i%0d.in_ready", i),   rdy[i],   !e_busy[i]);
            check($sformatf("i%0d.busy", i),       bsy[i],   e_busy[i]);
            check($sformatf("i%0d.sweep_done", i), dn[i],    e_done[i]);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic run_to_done(input int i, output int n);
        n = 1;
        while (!dn[i] && n < 64) begin
            cycle();
            n++;
        end
    endtask

    typedef struct {
        int          inst;
        logic [4:0]  idx;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        int n;

        vecs[0]  = '{0, 5'd7,  2'b00, 32'h0000_0080};
        vecs[1]  = '{0, 5'd3,  2'b01, 32'h0000_000E};
        vecs[2]  = '{1, 5'd3,  2'b01, 32'h0000_000F};
        vecs[3]  = '{0, 5'd31, 2'b10, 32'h7FFF_FFFE};
        vecs[4]  = '{0, 5'd7,  2'b11, 32'h0000_0080};
        vecs[5]  = '{1, 5'd0,  2'b00, 32'h0000_0001};
        vecs[6]  = '{0, 5'd0,  2'b00, 32'h0000_0000};
        vecs[7]  = '{1, 5'd0,  2'b10, 32'hFFFF_FFFE};
        vecs[8]  = '{2, 5'd7,  2'b01, 32'h0000_00FF};
        vecs[9]  = '{2, 5'd2,  2'b10, 32'h0000_00FB};
        vecs[10] = '{0, 5'd31, 2'b01, 32'hFFFF_FFFE};
        vecs[11] = '{1, 5'd31, 2'b01, 32'hFFFF_FFFF};
        vecs[12] = '{2, 5'd5,  2'b00, 32'h0000_0020};
        vecs[13] = '{1, 5'd31, 2'b11, 32'h8000_0000};

        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; in_s[i] = '0; md[i] = '0; ss[i] = 1'b0;
        end
        model_reset();

        // Reset state
        #3;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst.i%0d.out", i),        out_s[i], 32'h0);
            check($sformatf("rst.i%0d.out_valid", i),  ov[i],    1'b0);
            check($sformatf("rst.i%0d.in_ready", i),   rdy[i],   1'b1);
            check($sformatf("rst.i%0d.busy", i),       bsy[i],   1'b0);
            check($sformatf("rst.i%0d.sweep_done", i), dn[i],    1'b0);
        end
        cycle();
        cycle();
        reset_n = 1'b1;

        // Table-driven single decodes, each followed by an idle cycle
        for (int v = 0; v < 14; v++) begin
            iv[vecs[v].inst]   = 1'b1;
            in_s[vecs[v].inst] = vecs[v].idx;
            md[vecs[v].inst]   = vecs[v].mode;
            cycle();
            check($sformatf("vec%0d.out", v),   out_s[vecs[v].inst], vecs[v].exp);
            check($sformatf("vec%0d.valid", v), ov[vecs[v].inst],    1'b1);
            iv[vecs[v].inst] = 1'b0;
            cycle();
            check($sformatf("vec%0d.idle_out", v),   out_s[vecs[v].inst], 32'h0);
            check($sformatf("vec%0d.idle_valid", v), ov[vecs[v].inst],    1'b0);
        end

        // Masked sweep with a held request and a second sweep_start mid-sweep
        ss[0] = 1'b1;
        md[0] = 2'b00;
        cycle();
        ss[0]   = 1'b0;
        iv[0]   = 1'b1;
        in_s[0] = 5'd9;
        steps   = 0;
        while (steps < 40) begin
            steps++;
            check("sweep.line", out_s[0], 32'(1) << steps);
            check("sweep.in_ready_low", rdy[0], 1'b0);
            if (dn[0]) break;
            ss[0] = (steps == 5);
            cycle();
        end
        check("sweep.len", steps, 31);
        check("sweep.done_out", out_s[0], 32'h8000_0000);
        ss[0] = 1'b0;
        cycle();
        check("sweep.ready_again", rdy[0], 1'b1);
        cycle();
        check("sweep.held_req", out_s[0], 32'h0000_0200);
        iv[0] = 1'b0;
        cycle();

        // sweep_start and a request in the same cycle
        ss[0] = 1'b1; iv[0] = 1'b1; in_s[0] = 5'd2; md[0] = 2'b00;
        cycle();
        check("coll.decode", out_s[0], 32'h0000_0004);
        check("coll.busy", bsy[0], 1'b1);
        ss[0] = 1'b0; iv[0] = 1'b0;
        cycle();
        check("coll.first_step", out_s[0], 32'h0000_0002);
        run_to_done(0, n);
        check("coll.len", n, 31);
        cycle();

        // Reset in the middle of a sweep
        ss[0] = 1'b1;
        cycle();
        ss[0] = 1'b0;
        for (int t = 0; t < 9; t++) cycle();
        check("abort.step10", out_s[0], 32'h0000_0400);
        #2 reset_n = 1'b0;
        #1;
        check("abort.out", out_s[0], 32'h0);
        check("abort.valid", ov[0], 1'b0);
        check("abort.busy", bsy[0], 1'b0);
        check("abort.done", dn[0], 1'b0);
        check("abort.ready", rdy[0], 1'b1);
        model_reset();
        cycle();
        reset_n = 1'b1;
        iv[0] = 1'b1; in_s[0] = 5'd7; md[0] = 2'b00;
        cycle();
        check("abort.req_after", out_s[0], 32'h0000_0080);
        iv[0] = 1'b0;
        cycle();
        check("abort.no_resume", bsy[0], 1'b0);

        // Narrow instance: every index and mode, then a full sweep
        for (int m = 0; m < 4; m++) begin
            for (int x = 0; x < 8; x++) begin
                iv[2] = 1'b1; in_s[2] = 5'(x); md[2] = 2'(m);
                cycle();
                check($sformatf("exh.m%0d.in%0d", m, x), out_s[2], ref_decode(2, 5'(x), 2'(m)));
            end
        end
        iv[2] = 1'b0;
        cycle();
        ss[2] = 1'b1;
        cycle();
        ss[2] = 1'b0;
        check("sweep3.first", out_s[2], 32'h0000_0001);
        run_to_done(2, n);
        check("sweep3.len", n, 8);
        cycle();

        // Randomized traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i]   = 1'($urandom_range(0, 1));
                in_s[i] = 5'($urandom);
                md[i]   = 2'($urandom);
                ss[i]   = ($urandom_range(0, 19) == 0);
            end
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ss[i] = 1'b0;
        end
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
